// File: rtl/dtrigger_pipe.sv
// WIDTH-bit, DEPTH-stage delay line with per-stage valid bits, stall (en),
// synchronous flush (clr) and an occupancy counter of valid beats in flight.
module dtrigger_pipe #(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 3,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter bit               ZERO_INVALID = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  input  logic                       en,
  input  logic                       clr,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int OW = $clog2(DEPTH+1);

  // Handshake: d_valid qualifies d on any edge where en=1 and clr=0. There is
  // no ready; upstream stalls by dropping en, which freezes every stage, so a
  // beat is taken exactly once and leaves exactly once.
  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [OW-1:0]    occ_r;
  logic [WIDTH-1:0] d_in;

  assign d_in = (ZERO_INVALID && !d_valid) ? RESET_VAL : d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      vld   <= '0;
      occ_r <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      vld   <= '0;
      occ_r <= '0;
    end else if (en) begin
      stage[0] <= d_in;
      vld[0]   <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
        vld[i]   <= vld[i-1];
      end
      // Entry and exit on the same edge cancel, so the count stays in 0..DEPTH.
      occ_r <= occ_r + OW'(d_valid) - OW'(vld[DEPTH-1]);
    end
  end

  assign q       = stage[DEPTH-1];
  assign q_valid = vld[DEPTH-1];
  assign occ     = occ_r;

endmodule
